i2c_temp_reader: RTL

I2C master that fetches one temperature sample per request from an I2C temperature sensor and presents it as a parallel word with a valid strobe. It sits between the sensor pins and the threshold comparator. It performs a pointer write followed by a two-byte read, then hands the upper `BIT_WIDTH` bits of the returned word downstream.

---
 rtl/i2c_temp_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_temp_reader.sv
// i2c_temp_reader: I2C master that reads one temperature sample per request.
// Each transaction writes the register pointer, issues a repeated START and
// reads two bytes. The upper BIT_WIDTH bits of {MSB,LSB} are then presented
// on temp.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      request a read (sampled only in IDLE)
//   busy       transaction in progress
//   temp       last successfully read sample
//   temp_valid one-cycle pulse when temp updates
//   ack_err    one-cycle pulse when a transaction aborts on a slave NACK
//   scl        SCL, push-pull
//   sda_oe     1 pulls SDA low, 0 releases it
//   sda_i      synchronised SDA line level
module i2c_temp_reader #(
  parameter int unsigned CLK_DIV   = 25,
  parameter logic [6:0]  DEV_ADDR  = 7'h48,
  parameter logic [7:0]  REG_ADDR  = 8'h00,
  parameter int unsigned BIT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] temp,
  output logic                 temp_valid,
  output logic                 ack_err,
  output logic                 scl,
  output logic                 sda_oe,
  input  logic                 sda_i
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, WR_ADDR, WR_REG, RSTART, RD_ADDR, RD_MSB, RD_LSB, STOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [3:0]    bitn;
  logic [15:0]   shreg;
  logic          nack, err, err_n;
  logic          hold;      // SDA level at Q3 of the previous symbol
  logic          tick, sym_end, is_byte, sample;
  logic [7:0]    tx_byte;
  logic          drive_bit;

  always_comb begin
    tick    = (qcnt == CW'(CLK_DIV - 1));
    sym_end = tick && (quarter == 2'd3);
    is_byte = state inside {WR_ADDR, WR_REG, RD_ADDR, RD_MSB, RD_LSB};
    sample  = is_byte && tick && (quarter == 2'd2);
  end

  // Next state
  always_comb begin
    state_n = state;
    err_n   = err;
    case (state)
      IDLE:    if (start) begin
                 state_n = START;
                 err_n   = 1'b0;
               end
      START:   if (sym_end) state_n = WR_ADDR;
      WR_ADDR: if (sym_end && bitn == 4'd8) begin
                 if (nack) begin
                   state_n = STOP;
                   err_n   = 1'b1;
                 end else begin
                   state_n = WR_REG;
                 end
               end
      WR_REG:  if (sym_end && bitn == 4'd8) begin
                 if (nack) begin
                   state_n = STOP;
                   err_n   = 1'b1;
                 end else begin
                   state_n = RSTART;
                 end
               end
      RSTART:  if (sym_end) state_n = RD_ADDR;
      RD_ADDR: if (sym_end && bitn == 4'd8) begin
                 if (nack) begin
                   state_n = STOP;
                   err_n   = 1'b1;
                 end else begin
                   state_n = RD_MSB;
                 end
               end
      RD_MSB:  if (sym_end && bitn == 4'd8) state_n = RD_LSB;
      RD_LSB:  if (sym_end && bitn == 4'd8) state_n = STOP;
      STOP:    if (sym_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs and status
  always_comb begin
    tx_byte   = '0;
    drive_bit = 1'b0;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    case (state)
      WR_ADDR: tx_byte = {DEV_ADDR, 1'b0};
      WR_REG:  tx_byte = REG_ADDR;
      RD_ADDR: tx_byte = {DEV_ADDR, 1'b1};
      default: tx_byte = '0;
    endcase
    case (state)
      WR_ADDR, WR_REG, RD_ADDR: drive_bit = (bitn != 4'd8) && !tx_byte[~bitn[2:0]];
      RD_MSB:                   drive_bit = (bitn == 4'd8);
      default:                  drive_bit = 1'b0;
    endcase
    case (state)
      START: begin
        scl    = 1'b1;
        sda_oe = quarter[1];
      end
      RSTART: begin
        scl    = (quarter != 2'd0);
        sda_oe = quarter[1];
      end
      STOP: begin
        scl    = (quarter != 2'd0);
        sda_oe = !quarter[1];
      end
      WR_ADDR, WR_REG, RD_ADDR, RD_MSB, RD_LSB: begin
        scl    = quarter[1];
        sda_oe = (quarter == 2'd0) ? hold : drive_bit;
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
    busy       = (state != IDLE) && (state != DONE);
    temp_valid = (state == DONE) && !err;
    ack_err    = (state == DONE) && err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bitn    <= '0;
      shreg   <= '0;
      nack    <= 1'b0;
      err     <= 1'b0;
      hold    <= 1'b0;
      temp    <= '0;
    end else begin
      state <= state_n;
      err   <= err_n;
      if (state == IDLE || state == DONE) begin
        qcnt    <= '0;
        quarter <= '0;
        bitn    <= '0;
        hold    <= 1'b0;
      end else if (tick) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
        if (quarter == 2'd3) begin
          // Carry SDA across the symbol boundary so Q0 keeps the old bit
          hold <= sda_oe;
          bitn <= (is_byte && bitn != 4'd8) ? bitn + 4'd1 : '0;
        end
      end else begin
        qcnt <= qcnt + 1'b1;
      end
      if (sample) begin
        if (bitn == 4'd8) begin
          nack <= sda_i;
        end else if (state inside {RD_MSB, RD_LSB}) begin
          shreg <= {shreg[14:0], sda_i};
        end
      end
      if (state == STOP && sym_end && !err) begin
        temp <= shreg[15 -: BIT_WIDTH];
      end
    end
  end

endmodule
